// File: rtl/detect_pkg.sv
// -----------------------------------------------------------------------------
// detect_pkg
//   Shared definitions for the transmit burst generator and the receive-window
//   logic: one-hot transmit FSM encoding and default carrier/burst timing.
//
//   Contents:
//     tx_state_e     - one-hot transmit FSM state (IDLE/DRIVE/DEAD/DONE)
//     DEF_HALF       - cycles per half carrier period (40 kHz at 100 MHz)
//     DEF_GUARD      - non-overlap cycles at the end of each half period
//     DEF_PULSE_NUM  - carrier periods per burst
//     DEF_DEAD       - ring-down cycles after the burst
// -----------------------------------------------------------------------------
package detect_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_DRIVE = 4'b0010,
    ST_DEAD  = 4'b0100,
    ST_DONE  = 4'b1000
  } tx_state_e;

  localparam int DEF_HALF      = 1250;
  localparam int DEF_GUARD     = 10;
  localparam int DEF_PULSE_NUM = 8;
  localparam int DEF_DEAD      = 100_000;

endpackage

// File: rtl/tx_burst_gen.sv
// -----------------------------------------------------------------------------
// tx_burst_gen
//   Transmit-side responder to the sequencer's enTx/overTx handshake. A rising
//   edge on enTx launches a burst of PULSE_NUM complementary carrier periods on
//   tx_p/tx_n, followed by a DEAD-cycle ring-down, after which overTx is raised
//   and held until enTx drops. enTx low in any non-IDLE state aborts to IDLE.
//
//   Handshake: enTx is a level request; a burst starts only on its 0->1
//   transition. overTx is a level acknowledge that stays high while enTx stays
//   high and falls on the edge after enTx is sampled low. A new burst requires
//   enTx to be low for at least one cycle first.
//
//   Ports:
//     clk_100    in   system clock
//     rst_n      in   asynchronous active-low reset
//     enTx       in   level enable from the sequencer
//     tx_p       out  positive-phase drive
//     tx_n       out  negative-phase drive
//     tx_active  out  high during DRIVE and DEAD
//     overTx     out  burst complete (level)
//     fsm_state  out  current one-hot FSM state, for observation
// -----------------------------------------------------------------------------
module tx_burst_gen
  import detect_pkg::*;
#(
  parameter int HALF      = DEF_HALF,
  parameter int GUARD     = DEF_GUARD,
  parameter int PULSE_NUM = DEF_PULSE_NUM,
  parameter int DEAD      = DEF_DEAD
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       enTx,
  output logic       tx_p,
  output logic       tx_n,
  output logic       tx_active,
  output logic       overTx,
  output logic [3:0] fsm_state
);

  // Counter widths are $clog2(max+1); a single-valued counter keeps 1 bit.
  localparam int P_W  = $clog2(2 * HALF);
  localparam int PC_W = (PULSE_NUM > 1) ? $clog2(PULSE_NUM) : 1;
  localparam int DC_W = (DEAD > 1) ? $clog2(DEAD) : 1;

  localparam logic [P_W-1:0]  P_LAST     = P_W'(2 * HALF - 1);
  localparam logic [P_W-1:0]  P_POS_END  = P_W'(HALF - GUARD);     // first guard cycle, positive half
  localparam logic [P_W-1:0]  P_NEG_BEG  = P_W'(HALF);
  localparam logic [P_W-1:0]  P_NEG_END  = P_W'(2 * HALF - GUARD); // first guard cycle, negative half
  localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_NUM - 1);
  localparam logic [DC_W-1:0] DEAD_LAST  = DC_W'(DEAD - 1);

  tx_state_e       state_q, state_d;
  logic [P_W-1:0]  p_q, p_d;
  logic [PC_W-1:0] pulse_q, pulse_d;
  logic [DC_W-1:0] dead_q, dead_d;
  logic            en_q;
  logic            en_rise;

  logic            tx_p_d, tx_n_d, tx_active_d, over_d;

  // en_q resets to 1 so an enTx already high at reset release is not
  // mistaken for a rising edge.
  assign en_rise = enTx & ~en_q;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b1;
    end else begin
      en_q <= enTx;
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      pulse_q <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      pulse_q <= pulse_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    pulse_d = pulse_q;
    dead_d  = dead_q;

    case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          state_d = ST_DRIVE;
          p_d     = '0;
          pulse_d = '0;
        end
      end
      ST_DRIVE: begin
        if (p_q == P_LAST) begin
          p_d = '0;
          if (pulse_q == PULSE_LAST) begin
            state_d = ST_DEAD;
            pulse_d = '0;
            dead_d  = '0;
          end else begin
            pulse_d = pulse_q + PC_W'(1);
          end
        end else begin
          p_d = p_q + P_W'(1);
        end
      end
      ST_DEAD: begin
        if (dead_q == DEAD_LAST) begin
          state_d = ST_DONE;
          dead_d  = '0;
        end else begin
          dead_d = dead_q + DC_W'(1);
        end
      end
      ST_DONE: begin
        // Held here while enTx stays high; the abort path below exits.
      end
      default: begin
        // Non-one-hot value: recover to a clean IDLE.
        state_d = ST_IDLE;
        p_d     = '0;
        pulse_d = '0;
        dead_d  = '0;
      end
    endcase

    // enTx low outside IDLE always wins, including over a terminal count.
    // This is also the normal DONE -> IDLE exit.
    if ((state_q != ST_IDLE) && !enTx) begin
      state_d = ST_IDLE;
      p_d     = '0;
      pulse_d = '0;
      dead_d  = '0;
    end
  end

  // Outputs are decoded from the next state/phase and registered, so they move
  // on the same edge as the state. The two drive windows are disjoint.
  always_comb begin
    tx_p_d      = 1'b0;
    tx_n_d      = 1'b0;
    tx_active_d = 1'b0;
    over_d      = 1'b0;
    if (state_d == ST_DRIVE) begin
      tx_p_d = (p_d < P_POS_END);
      tx_n_d = (p_d >= P_NEG_BEG) && (p_d < P_NEG_END);
    end
    tx_active_d = (state_d == ST_DRIVE) || (state_d == ST_DEAD);
    over_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tx_p      <= 1'b0;
      tx_n      <= 1'b0;
      tx_active <= 1'b0;
      overTx    <= 1'b0;
    end else begin
      tx_p      <= tx_p_d;
      tx_n      <= tx_n_d;
      tx_active <= tx_active_d;
      overTx    <= over_d;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_tx_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_tx_burst_gen
//   Directed bench for tx_burst_gen with HALF=10, GUARD=2, PULSE_NUM=3, DEAD=20.
//   Cycle numbering: enTx sampled high at edge k; values observed just after
//   edge k+i-1 belong to cycle k+i.
// -----------------------------------------------------------------------------
module tb_tx_burst_gen;

  localparam int HALF      = 10;
  localparam int GUARD     = 2;
  localparam int PULSE_NUM = 3;
  localparam int DEAD      = 20;
  localparam int DRV_CYC   = PULSE_NUM * 2 * HALF;   // 60
  localparam int TOT_CYC   = DRV_CYC + DEAD;         // 80

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_DRIVE = 4'b0010;
  localparam logic [3:0] S_DEAD  = 4'b0100;
  localparam logic [3:0] S_DONE  = 4'b1000;

  // ---------------- clock / reset ----------------
  logic       clk_100;
  logic       rst_n;
  logic       enTx;
  logic       tx_p, tx_n, tx_active, overTx;
  logic [3:0] fsm_state;

  initial begin
    clk_100 = 1'b0;
    forever #5 clk_100 = ~clk_100;
  end

  tx_burst_gen #(
    .HALF(HALF), .GUARD(GUARD), .PULSE_NUM(PULSE_NUM), .DEAD(DEAD)
  ) dut (
    .clk_100   (clk_100),
    .rst_n     (rst_n),
    .enTx      (enTx),
    .tx_p      (tx_p),
    .tx_n      (tx_n),
    .tx_active (tx_active),
    .overTx    (overTx),
    .fsm_state (fsm_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives must never overlap, in any state.
  always @(negedge clk_100) begin
    check_eq("no_overlap", {31'd0, tx_p & tx_n}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_txp"},   {31'd0, tx_p},      32'd0);
    check_eq({tag, "_txn"},   {31'd0, tx_n},      32'd0);
    check_eq({tag, "_act"},   {31'd0, tx_active}, 32'd0);
    check_eq({tag, "_over"},  {31'd0, overTx},    32'd0);
    check_eq({tag, "_state"}, {28'd0, fsm_state}, {28'd0, S_IDLE});
  endtask

  int rise_cnt, p_hi_cnt, n_hi_cnt;

  // Steps n cycles after enTx has been set high (caller sets it before the
  // sampling edge k) and compares each cycle k+i with the reference timeline.
  task automatic run_burst(input string tag, input int n);
    logic prev_p;
    logic e_p, e_n, e_act, e_over;
    logic [3:0] e_st;
    int ph;
    prev_p   = 1'b0;
    rise_cnt = 0;
    p_hi_cnt = 0;
    n_hi_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      e_p = 1'b0; e_n = 1'b0;
      if (i <= DRV_CYC) begin
        ph   = (i - 1) % (2 * HALF);
        e_p  = (ph <= HALF - GUARD - 1);
        e_n  = (ph >= HALF) && (ph <= 2 * HALF - GUARD - 1);
        e_st = S_DRIVE;
      end else if (i <= TOT_CYC) begin
        e_st = S_DEAD;
      end else begin
        e_st = S_DONE;
      end
      e_act  = (i <= TOT_CYC);
      e_over = (i > TOT_CYC);
      check_eq($sformatf("%s_txp@%0d", tag, i),   {31'd0, tx_p},      {31'd0, e_p});
      check_eq($sformatf("%s_txn@%0d", tag, i),   {31'd0, tx_n},      {31'd0, e_n});
      check_eq($sformatf("%s_act@%0d", tag, i),   {31'd0, tx_active}, {31'd0, e_act});
      check_eq($sformatf("%s_over@%0d", tag, i),  {31'd0, overTx},    {31'd0, e_over});
      check_eq($sformatf("%s_st@%0d", tag, i),    {28'd0, fsm_state}, {28'd0, e_st});
      if (tx_p && !prev_p) rise_cnt++;
      if (tx_p) p_hi_cnt++;
      if (tx_n) n_hi_cnt++;
      prev_p = tx_p;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    enTx  = 1'b0;

    // Reset values
    #12;
    check_idle("reset");
    #5 rst_n = 1'b1;
    step(); step();
    check_idle("post_reset");

    // Nominal burst: enTx sampled high at edge k, observe cycles k+1..k+81
    enTx = 1'b1;
    run_burst("nom", TOT_CYC + 1);
    check_eq("nom_rises",  rise_cnt, 32'd3);
    check_eq("nom_p_hi",   p_hi_cnt, 32'd24);
    check_eq("nom_n_hi",   n_hi_cnt, 32'd24);
    // Hold enTx high 50 more cycles: no retrigger, overTx held
    for (int i = 0; i < 50; i++) begin
      step();
      check_eq("hold_over", {31'd0, overTx},    32'd1);
      check_eq("hold_act",  {31'd0, tx_active}, 32'd0);
      check_eq("hold_txp",  {31'd0, tx_p},      32'd0);
    end
    // Drop enTx: overTx falls one edge later
    enTx = 1'b0;
    step();
    check_idle("drop");
    // One-cycle low pulse then high -> fresh burst
    enTx = 1'b1;
    run_burst("rearm", 5);
    enTx = 1'b0;
    step();
    check_idle("rearm_drop");
    step();

    // DONE -> one low cycle -> high again restarts
    enTx = 1'b1;
    run_burst("pulse1", TOT_CYC + 3);
    enTx = 1'b0;
    step();
    check_idle("pulse1_low");
    enTx = 1'b1;
    run_burst("pulse1_new", 3);

    // Mid-burst abort: drop at k+25, zero from k+26, re-raise at k+30
    enTx = 1'b0;
    step(); step();
    enTx = 1'b1;
    run_burst("mid", 25);
    enTx = 1'b0;
    for (int i = 26; i <= 30; i++) begin
      step();
      check_idle($sformatf("mid_abort@%0d", i));
    end
    enTx = 1'b1;
    run_burst("mid_new", TOT_CYC + 1);

    // Abort sweep over every point 1..80 (80 = DEAD terminal, abort wins)
    for (int a = 1; a <= TOT_CYC; a++) begin
      enTx = 1'b0;
      step(); step();
      enTx = 1'b1;
      for (int i = 0; i < a; i++) step();
      enTx = 1'b0;
      step();
      check_idle($sformatf("sweep%0d", a));
    end
    step();

    // Asynchronous reset mid-DRIVE
    enTx = 1'b1;
    run_burst("rst_pre", 5);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    // Release with enTx still high: no burst until a rising edge
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("rst_en_hi");
    end
    enTx = 1'b0;
    step();
    check_idle("rst_en_lo");
    enTx = 1'b1;
    run_burst("rst_new", 12);

    enTx = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
